// File: rtl/inv_sqrt_newton_if.sv
// Operand/result handshake bundle for the inverse square root block.
// The master side supplies operands and consumes results; the slave side is the block itself.
interface inv_sqrt_newton_if #(
    parameter int INT_WIDTH   = 8,
    parameter int FRACT_WIDTH = 8
);
    localparam int W = INT_WIDTH + FRACT_WIDTH;

    logic        [W-1:0] data_in;
    logic                valid_in;
    logic                ready_in;
    logic signed [W-1:0] data_out;
    logic                valid_out;
    logic                ready_out;
    logic                zero_flag;

    modport master (
        output data_in,
        output valid_in,
        input  ready_in,
        input  data_out,
        input  valid_out,
        output ready_out,
        input  zero_flag
    );

    modport slave (
        input  data_in,
        input  valid_in,
        output ready_in,
        output data_out,
        output valid_out,
        input  ready_out,
        output zero_flag
    );
endinterface

// File: rtl/inv_sqrt_newton.sv
// Iterative 1/sqrt(x) for an unsigned Q(INT_WIDTH.FRACT_WIDTH) operand.
// A power-of-two seed is refined by Newton-Raphson y = y*(1.5 - x*y*y/2),
// one multiply per state through a single shared multiplier. Results are
// rounded half-up, saturated, and presented with a valid/ready handshake.
module inv_sqrt_newton #(
    parameter int INT_WIDTH   = 8,
    parameter int FRACT_WIDTH = 8,
    parameter int ITERATIONS  = 3
) (
    input logic              clk,
    input logic              rst_n,
    inv_sqrt_newton_if.slave bus
);
    localparam int W   = INT_WIDTH + FRACT_WIDTH;
    localparam int FW2 = 2 * FRACT_WIDTH;
    // Working format: two guard integer bits above the operand range, doubled fraction.
    localparam int IW  = INT_WIDTH + 2 + FW2;
    localparam int PW  = 2 * IW;

    localparam logic signed [W-1:0]  OUT_MAX      = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [IW-1:0] THREE_HALVES = IW'(3) <<< (FW2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        SQ,
        MUL,
        SUB,
        UPD,
        OUT
    } state_t;

    state_t              state_q,     state_d;
    logic        [W-1:0] x_q,         x_d;
    logic signed [IW-1:0] y_q,        y_d;
    logic signed [IW-1:0] t_q,        t_d;
    logic        [2:0]   iter_q,      iter_d;
    logic                ready_in_q,  ready_in_d;
    logic                valid_out_q, valid_out_d;
    logic signed [W-1:0] data_out_q,  data_out_d;
    logic                zero_q,      zero_d;

    logic signed [IW-1:0] x_ext;
    logic signed [IW-1:0] mul_a;
    logic signed [IW-1:0] mul_b;
    logic signed [IW-1:0] mul_t;

    // Seed from the leading-one position: 2^(-e/2) for even e, 0.703125*2^(-(e-1)/2) for odd e.
    function automatic logic signed [IW-1:0] seed_of(input logic [W-1:0] x);
        int p;
        int e;
        int s;
        logic signed [IW-1:0] base;
        p = 0;
        for (int i = 0; i < W; i++) begin
            if (x[i]) p = i;
        end
        e = p - FRACT_WIDTH;
        if (e % 2 == 0) begin
            base = IW'(1);
            s    = FW2 - e / 2;
        end else begin
            // 0.703125 = 45/64
            base = IW'(45);
            s    = FW2 - 6 - (e - 1) / 2;
        end
        if (s >= 0) return base <<< s;
        else        return base >>> (-s);
    endfunction

    // Working-format product, truncated (floor) back to the working format.
    function automatic logic signed [IW-1:0] mul_trunc(input logic signed [IW-1:0] a,
                                                       input logic signed [IW-1:0] b);
        logic signed [PW-1:0] p;
        p = PW'(a) * PW'(b);
        return IW'(p >>> FW2);
    endfunction

    // Round half-up to the output fraction and clip at the largest positive output code.
    function automatic logic signed [W-1:0] round_sat(input logic signed [IW-1:0] y);
        logic signed [IW:0] sum;
        logic signed [IW:0] q;
        sum = {y[IW-1], y} + ((IW+1)'(1) <<< (FRACT_WIDTH - 1));
        q   = sum >>> FRACT_WIDTH;
        if (q > (IW+1)'(OUT_MAX)) return OUT_MAX;
        else                      return W'(q);
    endfunction

    assign x_ext = $signed({2'b00, x_q, {FRACT_WIDTH{1'b0}}});
    assign mul_t = mul_trunc(mul_a, mul_b);

    assign bus.ready_in  = ready_in_q;
    assign bus.valid_out = valid_out_q;
    assign bus.data_out  = data_out_q;
    assign bus.zero_flag = zero_q;

    // Next-state, operand selection for the shared multiplier, and output staging.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        t_d         = t_q;
        iter_d      = iter_q;
        ready_in_d  = ready_in_q;
        valid_out_d = valid_out_q;
        data_out_d  = data_out_q;
        zero_d      = zero_q;
        mul_a       = y_q;
        mul_b       = y_q;

        case (state_q)
            IDLE: begin
                if (ready_in_q && bus.valid_in) begin
                    x_d        = bus.data_in;
                    ready_in_d = 1'b0;
                    state_d    = SEED;
                end else begin
                    ready_in_d = 1'b1;
                end
            end
            SEED: begin
                iter_d = '0;
                if (x_q == '0) begin
                    state_d = OUT;
                end else begin
                    y_d     = seed_of(x_q);
                    state_d = SQ;
                end
            end
            SQ: begin
                mul_a   = y_q;
                mul_b   = y_q;
                t_d     = mul_t;
                state_d = MUL;
            end
            MUL: begin
                mul_a   = x_ext;
                mul_b   = t_q;
                t_d     = mul_t;
                state_d = SUB;
            end
            SUB: begin
                t_d     = THREE_HALVES - (t_q >>> 1);
                state_d = UPD;
            end
            UPD: begin
                mul_a = y_q;
                mul_b = t_q;
                y_d   = mul_t;
                if (iter_q == 3'(ITERATIONS - 1)) begin
                    state_d = OUT;
                end else begin
                    iter_d  = iter_q + 3'd1;
                    state_d = SQ;
                end
            end
            OUT: begin
                // First cycle here publishes the result; afterwards wait for the consumer.
                if (!valid_out_q) begin
                    valid_out_d = 1'b1;
                    if (x_q == '0) begin
                        data_out_d = OUT_MAX;
                        zero_d     = 1'b1;
                    end else begin
                        data_out_d = round_sat(y_q);
                        zero_d     = 1'b0;
                    end
                end else if (bus.ready_out) begin
                    valid_out_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything and discards any in-flight operand.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            t_q         <= '0;
            iter_q      <= '0;
            ready_in_q  <= 1'b0;
            valid_out_q <= 1'b0;
            data_out_q  <= '0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            t_q         <= t_d;
            iter_q      <= iter_d;
            ready_in_q  <= ready_in_d;
            valid_out_q <= valid_out_d;
            data_out_q  <= data_out_d;
            zero_q      <= zero_d;
        end
    end
endmodule

// File: doc/inv_sqrt_newton.md
INV_SQRT_NEWTON -- requirements
Module: inv_sqrt_newton

Interface
REQ-001 SHALL have parameter INT_WIDTH, default 8: integer bits of the data_in/data_out fixed-point format.
REQ-002 SHALL have parameter FRACT_WIDTH, default 8: fractional bits. W = INT_WIDTH+FRACT_WIDTH.
REQ-003 SHALL have parameter ITERATIONS, default 3: Newton-Raphson iteration count, legal range 1..7.
REQ-004 SHALL have port clk, input, 1: clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port data_in, input, W: unsigned operand x, format Q(INT_WIDTH.FRACT_WIDTH).
REQ-007 SHALL have port valid_in, input, 1: the upstream block presents an operand.
REQ-008 SHALL have port ready_in, output, 1: the block can accept an operand.
REQ-009 SHALL have port data_out, output, W: signed result 1/sqrt(x), same Q format.
REQ-010 SHALL have port valid_out, output, 1: the result is available.
REQ-011 SHALL have port ready_out, input, 1: downstream accepts the result.
REQ-012 SHALL have port zero_flag, output, 1: the current result came from x=0.

Function
REQ-013 SHALL implement states IDLE, SEED, SQ, MUL, SUB, UPD, OUT; IDLE->SEED on valid_in&&ready_in; SEED->OUT if x=0, else SEED->SQ; SQ->MUL->SUB->UPD; UPD->SQ while iterations remain, else UPD->OUT; OUT->IDLE on valid_out&&ready_out.
REQ-014 SHALL drive ready_in high only in IDLE, from a register; valid_in outside IDLE SHALL be ignored.
REQ-015 SHALL capture data_in on the accepting edge; later changes to data_in SHALL have no effect on the result.
REQ-016 SEED: p = index of the leading one of x, e = p-FRACT_WIDTH; for even e, y0 = 2^(-e/2); for odd e, y0 = 0.703125*2^(-(e-1)/2).
REQ-017 Each iteration SHALL use one multiply per state: SQ t=y*y; MUL t=x*t; SUB t=1.5-t/2; UPD y=y*t.
REQ-018 Intermediates SHALL use INT_WIDTH+2 integer bits and 2*FRACT_WIDTH fraction bits, truncating after each multiply.
REQ-019 The final y SHALL be rounded half-up to FRACT_WIDTH and saturated to 2^(W-1)-1 if it exceeds the positive range.
REQ-020 x=0 SHALL give data_out=2^(W-1)-1 and zero_flag=1; otherwise zero_flag SHALL be 0.
REQ-021 For x>0, valid_out SHALL rise 2+4*ITERATIONS edges after the accepting edge (14 at default); for x=0, 2 edges after it.
REQ-022 data_out, zero_flag and valid_out SHALL be registered and held stable while valid_out=1 and ready_out=0.
REQ-023 On the valid_out&&ready_out edge, valid_out SHALL fall and the block SHALL enter IDLE; ready_in SHALL rise on the following edge, leaving a one-cycle bubble.
REQ-024 A ready_out that is already high when valid_out rises SHALL complete the transfer on the next edge.

Reset
REQ-025 While rst_n=0, the block SHALL hold state IDLE, ready_in=0, valid_out=0, data_out=0, zero_flag=0, and all intermediates at 0.
REQ-026 The first rising clk edge with rst_n=1 SHALL set ready_in=1.
REQ-027 Reset asserted mid-computation SHALL discard the in-flight operation with no spurious valid_out after release.

Verification
REQ-028 x=0x0100 (1.0) accepted -> data_out=0x0100 and zero_flag=0 exactly 14 edges after acceptance.
REQ-029 x=0x0400 (4.0) -> 0x0080; x=0x0001 -> 0x1000; x=0x0200 (2.0) -> 0x00B5 within +/-1 LSB.
REQ-030 x=0 -> data_out=0x7FFF and zero_flag=1 at 2 edges after acceptance; ready_in low throughout.
REQ-031 Hold ready_out=0 for 10 cycles after valid_out -> data_out and valid_out stable; release -> one transfer, then ready_in=1 one edge later.
REQ-032 Assert rst_n=0 at SUB of iteration 2 -> all outputs 0 immediately; after release, no valid_out and ready_in=1.
REQ-033 Random sweep of 10k x in [0x0001, 0xFFFF] with random valid_in/ready_out stalls -> every result within +/-2 LSB of the ideal saturated value, no lost or duplicated transfers.
